// File: rtl/vec_add_pkg.sv
// Shared types and elaboration helpers for the folded vector-add sequencer.
package vec_add_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    // Number of series cycles needed to cover the whole vector.
    function automatic int series(input int vec_len, input int lanes);
        return vec_len / lanes;
    endfunction

    // Width of the series counter; at least one bit even when SERIES == 1.
    function automatic int sidx_w(input int vec_len, input int lanes);
        int s;
        s = vec_len / lanes;
        return (s <= 1) ? 1 : $clog2(s);
    endfunction

    // LSB position of element idx in a flat vector of width-bit elements.
    function automatic int elem_lsb(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/vec_add_series_ctrl_if.sv
// Operand / result handshake bundle for the folded vector adder.
interface vec_add_series_ctrl_if #(
    parameter int VEC_LEN   = 10,
    parameter int IN_WIDTH  = 10,
    parameter int OUT_WIDTH = IN_WIDTH + 1
);
    logic                           in_valid;
    logic                           in_ready;
    logic [VEC_LEN*IN_WIDTH-1:0]    a_flat;
    logic [VEC_LEN*IN_WIDTH-1:0]    b_flat;
    logic                           out_valid;
    logic                           out_ready;
    logic [VEC_LEN*OUT_WIDTH-1:0]   out_data;

    modport master (
        output in_valid, a_flat, b_flat, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, a_flat, b_flat, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/vec_add_lanes.sv
// LANES parallel sign-extending combinational adders.
module vec_add_lanes #(
    parameter int LANES     = 5,
    parameter int IN_WIDTH  = 10,
    parameter int OUT_WIDTH = IN_WIDTH + 1
) (
    input  logic [LANES-1:0][IN_WIDTH-1:0]  a_i,
    input  logic [LANES-1:0][IN_WIDTH-1:0]  b_i,
    output logic [LANES-1:0][OUT_WIDTH-1:0] sum_o
);
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        // Signed size casts sign-extend both operands before the add.
        assign sum_o[l] = OUT_WIDTH'($signed(a_i[l])) + OUT_WIDTH'($signed(b_i[l]));
    end
endmodule

// File: rtl/vec_add_series_ctrl.sv
// Sequencer driving LANES shared adders over VEC_LEN/LANES series cycles.
// Optional macro VEC_ADD_SERIES_CTRL_EARLY_OUT_EN enables the early_out_ready
// prefetch pulse; without it early_out_ready is tied low.
module vec_add_series_ctrl
    import vec_add_pkg::*;
#(
    parameter int VEC_LEN   = 10,
    parameter int LANES     = 5,
    parameter int IN_WIDTH  = 10,
    parameter int OUT_WIDTH = IN_WIDTH + 1
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 enable,
    vec_add_series_ctrl_if.slave                 bus,
    output logic                                 new_series_start,
    output logic [sidx_w(VEC_LEN, LANES)-1:0]    series_idx,
    output logic                                 early_out_ready
);
    localparam int SERIES = series(VEC_LEN, LANES);
    localparam int SIDX_W = sidx_w(VEC_LEN, LANES);
    localparam int VW_IN  = VEC_LEN * IN_WIDTH;
    localparam int VW_OUT = VEC_LEN * OUT_WIDTH;
    localparam logic [SIDX_W-1:0] LAST = SIDX_W'(SERIES - 1);

    if (VEC_LEN % LANES != 0) begin : g_bad_cfg
        $error("vec_add_series_ctrl: VEC_LEN must be a multiple of LANES");
    end

    state_e              state_q, state_d;
    logic [SIDX_W-1:0]   sidx_q, sidx_d;
    logic [VW_IN-1:0]    a_q, a_d, b_q, b_d;
    logic [VW_OUT-1:0]   res_q, res_d;
    logic                ov_q, ov_d;
    logic                in_ready_w, accept, rel;

    logic [LANES-1:0][IN_WIDTH-1:0]  lane_a, lane_b;
    logic [LANES-1:0][OUT_WIDTH-1:0] lane_sum;

    // Ready in IDLE, or in DONE when the result is leaving this cycle.
    always_comb begin
        in_ready_w = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
    end

    assign accept = enable && bus.in_valid && in_ready_w;
    assign rel    = enable && ov_q && bus.out_ready;

    // Operand mux: pick this series' slice of A and B for the shared lanes.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_a[l] = a_q[elem_lsb(int'(sidx_q) * LANES + l, IN_WIDTH) +: IN_WIDTH];
            lane_b[l] = b_q[elem_lsb(int'(sidx_q) * LANES + l, IN_WIDTH) +: IN_WIDTH];
        end
    end

    vec_add_lanes #(
        .LANES     (LANES),
        .IN_WIDTH  (IN_WIDTH),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_lanes (
        .a_i   (lane_a),
        .b_i   (lane_b),
        .sum_o (lane_sum)
    );

    // Next-state logic; every transition is qualified by enable so a low
    // enable freezes the whole block.
    always_comb begin
        state_d = state_q;
        sidx_d  = sidx_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        ov_d    = ov_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d     = bus.a_flat;
                    b_d     = bus.b_flat;
                    sidx_d  = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (enable) begin
                    for (int l = 0; l < LANES; l++) begin
                        res_d[elem_lsb(int'(sidx_q) * LANES + l, OUT_WIDTH) +: OUT_WIDTH] = lane_sum[l];
                    end
                    if (sidx_q == LAST) begin
                        sidx_d  = '0;
                        ov_d    = 1'b1;
                        state_d = DONE;
                    end else begin
                        sidx_d = sidx_q + SIDX_W'(1);
                    end
                end
            end
            DONE: begin
                if (rel) begin
                    ov_d = 1'b0;
                    if (accept) begin
                        a_d     = bus.a_flat;
                        b_d     = bus.b_flat;
                        sidx_d  = '0;
                        state_d = RUN;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, operand and result registers; reset discards any transaction.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sidx_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sidx_q  <= sidx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            ov_q    <= ov_d;
        end
    end

`ifdef VEC_ADD_SERIES_CTRL_EARLY_OUT_EN
    logic early_q;

    // High exactly while the last series is in flight, i.e. one cycle
    // before out_valid rises.
    always_ff @(posedge clk) begin
        if (reset) early_q <= 1'b0;
        else       early_q <= (state_d == RUN) && (sidx_d == LAST);
    end

    assign early_out_ready = early_q;
`else
    assign early_out_ready = 1'b0;
`endif

    assign bus.in_ready     = in_ready_w;
    assign bus.out_valid    = ov_q;
    assign bus.out_data     = res_q;
    assign series_idx       = sidx_q;
    assign new_series_start = (sidx_q == '0);

endmodule
